// File: rtl/chain_pulse_meter_if.sv
// chain_pulse_meter_if
//   Bundles the run-control, configuration and status signals of
//   chain_pulse_meter. The master side (test controller) drives start and the
//   run configuration; the slave side (the meter) returns the chain stimulus,
//   the raw chain output and the run status.
//
//   Signals
//     start        master->slave  begin a measurement run (sampled in IDLE)
//     pulse_width  master->slave  high cycles per stimulus pulse
//     gap_width    master->slave  low cycles after each pulse
//     pulse_count  master->slave  pulses per run
//     tap_sel      master->slave  observation tap (only with CHAIN_TAP_SELECT_EN)
//     stim         slave->master  registered chain input
//     chain_out    slave->master  raw output of the last group
//     busy         slave->master  run in progress
//     done         slave->master  one-cycle end-of-run pulse
//     edges_seen   slave->master  rising edges counted at the observation point
//
//   Optional macro: CHAIN_TAP_SELECT_EN adds tap_sel.
interface chain_pulse_meter_if #(
    parameter int GROUPS = 13,
    parameter int W_W    = 8,
    parameter int N_W    = 8
);
    localparam int TAP_W = $clog2(GROUPS + 1);

    logic           start;
    logic [W_W-1:0] pulse_width;
    logic [W_W-1:0] gap_width;
    logic [N_W-1:0] pulse_count;
`ifdef CHAIN_TAP_SELECT_EN
    logic [TAP_W-1:0] tap_sel;
`endif
    logic           stim;
    logic           chain_out;
    logic           busy;
    logic           done;
    logic [N_W-1:0] edges_seen;

`ifdef CHAIN_TAP_SELECT_EN
    modport master (
        output start, pulse_width, gap_width, pulse_count, tap_sel,
        input  stim, chain_out, busy, done, edges_seen
    );
    modport slave (
        input  start, pulse_width, gap_width, pulse_count, tap_sel,
        output stim, chain_out, busy, done, edges_seen
    );
`else
    modport master (
        output start, pulse_width, gap_width, pulse_count,
        input  stim, chain_out, busy, done, edges_seen
    );
    modport slave (
        input  start, pulse_width, gap_width, pulse_count,
        output stim, chain_out, busy, done, edges_seen
    );
`endif
endinterface

// File: rtl/chain_pulse_meter.sv
// chain_pulse_meter
//   Delay-chain pulse-degradation meter. A chain of GROUPS NOR2/NOR2/INV
//   groups is driven by an on-chip pulse-train generator; the pulses that
//   survive at the (polarity-corrected) chain output are synchronised and
//   counted.
//
//   Ports
//     clk   in   sole clock, rising edge
//     rst   in   asynchronous active-high reset
//     bus   slave modport of chain_pulse_meter_if (start/config in,
//           stim/chain_out/busy/done/edges_seen out)
//
//   Optional macro: CHAIN_TAP_SELECT_EN -- observe the output of group
//   tap_sel-1 (tap_sel=0 observes stim) instead of the chain end.
module chain_pulse_meter #(
    parameter int GROUPS = 13,
    parameter int W_W    = 8,
    parameter int N_W    = 8
) (
    input logic               clk,
    input logic               rst,
    chain_pulse_meter_if.slave bus
);
    localparam int DRAIN_CYCLES = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic           stim_q, stim_d;
    logic [W_W-1:0] cnt_q, cnt_d;
    logic [N_W-1:0] rem_q, rem_d;
    logic [W_W-1:0] w_q, w_d;
    logic [W_W-1:0] g_q, g_d;
    logic           sync1_q, sync1_d;
    logic           sync2_q, sync2_d;
    logic           prev_q, prev_d;
    logic [N_W-1:0] edges_q, edges_d;
    logic           obs;
    logic           rise;

    // A programmed width or gap of zero still occupies one cycle.
    function automatic logic [W_W-1:0] nz_width(input logic [W_W-1:0] v);
        return (v == '0) ? W_W'(1) : v;
    endfunction

    // ---- delay chain: node[i] is the input of group i, node[GROUPS] the end
    wire              tie_lo;
    wire [GROUPS:0]   node;
    wire [GROUPS-1:0] nor_a;
    wire [GROUPS-1:0] nor_b;

    assign tie_lo  = 1'b0;
    assign node[0] = stim_q;

    for (genvar i = 0; i < GROUPS; i++) begin : g_grp
        nor u_nor_a (nor_a[i], tie_lo, node[i]);
        nor u_nor_b (nor_b[i], nor_a[i], tie_lo);
        not u_inv   (node[i+1], nor_b[i]);
    end

    assign bus.chain_out = node[GROUPS];
    assign bus.stim      = stim_q;

    // ---- observation point and polarity correction (one inversion per group)
`ifdef CHAIN_TAP_SELECT_EN
    localparam int TAP_W = $clog2(GROUPS + 1);
    logic [TAP_W-1:0] tap_q, tap_d;

    assign obs = node[tap_q] ^ tap_q[0];
`else
    localparam bit CHAIN_ODD = (GROUPS % 2) == 1;

    assign obs = node[GROUPS] ^ CHAIN_ODD;
`endif

    // ---- synchroniser stage 1/2, then edge detector
    assign sync1_d = obs;
    assign sync2_d = sync1_q;
    assign prev_d  = sync2_q;
    assign rise    = sync2_q & ~prev_q;

    always_comb begin
        state_d = state_q;
        stim_d  = stim_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        w_d     = w_q;
        g_d     = g_q;
        edges_d = edges_q;
`ifdef CHAIN_TAP_SELECT_EN
        tap_d   = tap_q;
`endif

        if (rise && (edges_q != '1)) begin
            edges_d = edges_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                stim_d = 1'b0;
                if (bus.start) begin
                    w_d     = nz_width(bus.pulse_width);
                    g_d     = nz_width(bus.gap_width);
                    rem_d   = bus.pulse_count;
                    edges_d = '0;
`ifdef CHAIN_TAP_SELECT_EN
                    tap_d   = (bus.tap_sel > TAP_W'(GROUPS)) ? TAP_W'(GROUPS) : bus.tap_sel;
`endif
                    if (bus.pulse_count == '0) begin
                        state_d = S_DRAIN;
                        cnt_d   = W_W'(DRAIN_CYCLES - 1);
                    end else begin
                        state_d = S_HIGH;
                        stim_d  = 1'b1;
                        cnt_d   = nz_width(bus.pulse_width) - 1'b1;
                    end
                end
            end
            S_HIGH: begin
                if (cnt_q == '0) begin
                    state_d = S_LOW;
                    stim_d  = 1'b0;
                    cnt_d   = g_q - 1'b1;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                end
            end
            S_LOW: begin
                if (cnt_q == '0) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == N_W'(1)) begin
                        state_d = S_DRAIN;
                        cnt_d   = W_W'(DRAIN_CYCLES - 1);
                    end else begin
                        state_d = S_HIGH;
                        stim_d  = 1'b1;
                        cnt_d   = w_q - 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DRAIN: begin
                stim_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                stim_d  = 1'b0;
            end
        endcase
    end

    // ---- control and counting registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            stim_q  <= 1'b0;
            cnt_q   <= '0;
            rem_q   <= '0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            edges_q <= '0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            edges_q <= edges_d;
        end
    end

    // ---- latched run configuration (only read after a start has loaded it)
    always_ff @(posedge clk) begin
        w_q   <= w_d;
        g_q   <= g_d;
`ifdef CHAIN_TAP_SELECT_EN
        tap_q <= tap_d;
`endif
    end

    assign bus.busy       = (state_q == S_HIGH) || (state_q == S_LOW) || (state_q == S_DRAIN);
    assign bus.done       = (state_q == S_DONE);
    assign bus.edges_seen = edges_q;
endmodule

// File: tb/tb_chain_pulse_meter.sv
// Scoreboard bench for chain_pulse_meter: a driver launches runs and pushes
// the expected outcome of each run; a monitor pops an entry whenever done is
// seen and compares edge count, done timing, stimulus shape and chain
// polarity.
module tb_chain_pulse_meter;
    localparam int GROUPS = 13;
    localparam int W_W    = 8;
    localparam int N_W    = 8;
    localparam int TAP_W  = $clog2(GROUPS + 1);
    localparam int MAXC   = (1 << N_W) - 1;
    localparam bit ODD    = (GROUPS % 2) == 1;

    typedef struct {
        int edges;
        int done_cyc;
        int highs;
        int rises;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   done_seen = 0;
    exp_t sb_q[$];

    chain_pulse_meter_if #(.GROUPS(GROUPS), .W_W(W_W), .N_W(N_W)) bus ();

    chain_pulse_meter #(.GROUPS(GROUPS), .W_W(W_W), .N_W(N_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Drive a start from IDLE, confirm acceptance, and record what the run
    // must produce according to the pulse-train rules.
    task automatic launch(input int w, input int g, input int n, input int tap);
        exp_t e;
        int   we;
        int   ge;
        @(negedge clk);
        bus.pulse_width = W_W'(w);
        bus.gap_width   = W_W'(g);
        bus.pulse_count = N_W'(n);
`ifdef CHAIN_TAP_SELECT_EN
        bus.tap_sel     = TAP_W'(tap);
`else
        if (tap < 0) $display("tap %0d", tap);
`endif
        bus.start = 1'b1;
        @(negedge clk);
        bus.start       = 1'b0;
        bus.pulse_width = W_W'($urandom);
        bus.gap_width   = W_W'($urandom);
        bus.pulse_count = N_W'($urandom);
        check("accept_busy", bus.busy, 1);
        we = (w == 0) ? 1 : w;
        ge = (g == 0) ? 1 : g;
        e.edges    = (n > MAXC) ? MAXC : n;
        e.done_cyc = cyc + n * (we + ge) + 3;
        e.highs    = n * we;
        e.rises    = n;
        sb_q.push_back(e);
    endtask

    // Disturb start and the config inputs while busy; return in the done cycle.
    task automatic finish_run();
        int guard = 0;
        forever begin
            @(negedge clk);
            if (!bus.busy) begin
                bus.start = 1'b0;
                break;
            end
            bus.start       = ($urandom_range(0, 3) == 0);
            bus.pulse_width = W_W'($urandom);
            bus.gap_width   = W_W'($urandom);
            bus.pulse_count = N_W'($urandom);
`ifdef CHAIN_TAP_SELECT_EN
            bus.tap_sel     = TAP_W'($urandom);
`endif
            guard++;
            if (guard > 3000) begin
                check("run_timeout", guard, 0);
                bus.start = 1'b0;
                break;
            end
        end
    endtask

    task automatic run(input int w, input int g, input int n, input int tap);
        launch(w, g, n, tap);
        finish_run();
    endtask

    // Monitor: observes every cycle, scores each run at its done pulse.
    initial begin
        int  hi_cnt = 0;
        int  rise_cnt = 0;
        int  pol_err = 0;
        logic prev_stim = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                hi_cnt = 0;
                rise_cnt = 0;
                pol_err = 0;
                prev_stim = 1'b0;
            end else begin
                if (bus.stim) hi_cnt++;
                if (bus.stim && !prev_stim) rise_cnt++;
                prev_stim = bus.stim;
                if (bus.chain_out !== (bus.stim ^ ODD)) pol_err++;
                if (bus.done) begin
                    done_seen++;
                    check("done_expected", (sb_q.size() > 0), 1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        check("edges_seen", bus.edges_seen, e.edges);
                        check("done_cycle", cyc, e.done_cyc);
                        check("stim_high_cycles", hi_cnt, e.highs);
                        check("stim_pulses", rise_cnt, e.rises);
                        check("busy_at_done", bus.busy, 0);
                        check("chain_polarity_errs", pol_err, 0);
                    end
                    hi_cnt = 0;
                    rise_cnt = 0;
                    pol_err = 0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=%0d required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int g;
        int n;
        int d0;
        bus.start       = 1'b0;
        bus.pulse_width = '0;
        bus.gap_width   = '0;
        bus.pulse_count = '0;
`ifdef CHAIN_TAP_SELECT_EN
        bus.tap_sel     = '0;
`endif
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_stim", bus.stim, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_edges", bus.edges_seen, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", bus.busy, 0);
        check("idle_edges", bus.edges_seen, 0);

        // Directed runs: basic, polarity-style fast train, zero count,
        // zero widths, longest count.
        run(2, 3, 5, GROUPS);
        run(1, 1, 10, GROUPS);
        run(4, 2, 0, GROUPS);
        run(0, 0, 3, GROUPS);
        run(1, 1, MAXC, GROUPS);
        run(3, 3, 4, GROUPS);
        check("edges_hold_after_done", bus.edges_seen, 4);

`ifdef CHAIN_TAP_SELECT_EN
        run(3, 3, 4, 0);
        run(3, 3, 4, 1);
        run(3, 3, 4, 7);
        run(3, 3, 4, 13);
        run(3, 3, 4, (1 << TAP_W) - 1);
`endif

        // Reset mid-run while stim is high aborts without a done.
        launch(8, 2, 6, GROUPS);
        repeat (4) @(negedge clk);
        check("midrun_stim_high", bus.stim, 1);
        #2;
        rst = 1'b1;
        sb_q.delete();
        #1;
        check("abort_stim", bus.stim, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_edges", bus.edges_seen, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        d0 = done_seen;
        repeat (100) @(negedge clk);
        check("no_done_after_abort", done_seen - d0, 0);
        check("abort_idle_busy", bus.busy, 0);

        // Randomised runs.
        for (int i = 0; i < 25; i++) begin
            w = $urandom_range(0, 5);
            g = $urandom_range(0, 5);
            n = $urandom_range(0, 12);
            run(w, g, n, $urandom_range(0, (1 << TAP_W) - 1));
        end

        repeat (10) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
